// File: rtl/int_prio_arb.sv
// -----------------------------------------------------------------------------
// int_prio_arb
//
// Interrupt priority arbiter and handshake sequencer in front of the CPU
// interrupt pin. Source events are latched into pending bits, one winner is
// picked (fixed priority or round-robin), and an assert -> acknowledge ->
// end-of-interrupt handshake makes sure the CPU services exactly one source
// at a time while the vector stays stable.
//
// Parameters
//   N_SRC  number of interrupt sources (2..32)
//   VEC_W  vector width, ceil(log2(N_SRC))
//   RR     0 = fixed priority (index 0 highest), 1 = round-robin
//
// Ports
//   cpu_clk     in   clock, all logic on the rising edge
//   cpu_reset   in   asynchronous active-high reset
//   src_in      in   raw source lines (already synchronous to cpu_clk)
//   src_edge    in   per source: 1 = rising-edge triggered, 0 = level
//   src_en      in   per source enable
//   pend_clr    in   per source pulse clearing edge-mode pending bits
//   irq         out  registered interrupt request to the CPU
//   irq_vec     out  registered index of the requesting / in-service source
//   irq_ack     in   CPU accepts the current vector (pulse)
//   eoi         in   CPU end of interrupt (pulse)
//   pending     out  registered pending bits
//   in_service  out  one-hot in-service source, zero when none
// -----------------------------------------------------------------------------
module int_prio_arb #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3,
    parameter int RR    = 0
) (
    input  logic             cpu_clk,
    input  logic             cpu_reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] src_edge,
    input  logic [N_SRC-1:0] src_en,
    input  logic [N_SRC-1:0] pend_clr,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             eoi,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state_reg;
    logic             irq_reg;
    logic [VEC_W-1:0] irq_vec_reg;
    logic [VEC_W-1:0] ptr_reg;
    logic [N_SRC-1:0] in_service_reg;
    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] src_d_reg;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic             ack_fire;
    logic [VEC_W-1:0] winner;
    logic             winner_found;

    assign rise     = src_in & ~src_d_reg;
    assign eligible = pending_reg & src_en;
    // An acknowledge only counts while a request is actually on the pin.
    assign ack_fire = (state_reg == ST_ASSERT) && irq_ack;

    // Previous-cycle copy of the source lines for rising-edge detection.
    // Clearing it in reset means a line already high at release is an edge.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            src_d_reg <= '0;
        end else begin
            src_d_reg <= src_in;
        end
    end

    // Per-source pending bit. Edge mode: a new rise beats any clear in the
    // same cycle. Level mode: simply mirrors the line, clears are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_pend
            logic clr_bit;
            assign clr_bit = pend_clr[gi] | (ack_fire && (irq_vec_reg == VEC_W'(gi)));

            always_ff @(posedge cpu_clk or posedge cpu_reset) begin
                if (cpu_reset) begin
                    pending_reg[gi] <= 1'b0;
                end else if (src_edge[gi]) begin
                    if (rise[gi]) begin
                        pending_reg[gi] <= 1'b1;
                    end else if (clr_bit) begin
                        pending_reg[gi] <= 1'b0;
                    end
                end else begin
                    pending_reg[gi] <= src_in[gi];
                end
            end
        end
    endgenerate

    // Winner search: scan N_SRC positions starting at 'start'. Fixed priority
    // starts at 0; round-robin starts just after the last acknowledged source.
    always_comb begin
        int start;
        int idx;
        winner       = '0;
        winner_found = 1'b0;
        start        = (RR != 0) ? ((int'(ptr_reg) + 1) % N_SRC) : 0;
        idx          = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (start + k) % N_SRC;
            if (!winner_found && eligible[idx]) begin
                winner_found = 1'b1;
                winner       = VEC_W'(idx);
            end
        end
    end

    // Handshake sequencer. The vector is latched on entry to ASSERT and held
    // through SERVICE, so later arrivals never preempt the current request.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_reg      <= ST_IDLE;
            irq_reg        <= 1'b0;
            irq_vec_reg    <= '0;
            in_service_reg <= '0;
            ptr_reg        <= VEC_W'(N_SRC - 1);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    irq_reg <= 1'b0;
                    if (winner_found) begin
                        irq_vec_reg <= winner;
                        irq_reg     <= 1'b1;
                        state_reg   <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (irq_ack) begin
                        // Ack wins over a simultaneous drop of the source.
                        irq_reg                     <= 1'b0;
                        in_service_reg              <= '0;
                        in_service_reg[irq_vec_reg] <= 1'b1;
                        ptr_reg                     <= irq_vec_reg;
                        state_reg                   <= ST_SERVICE;
                    end else if (!eligible[irq_vec_reg]) begin
                        // Source went away before the CPU took it: withdraw.
                        irq_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    irq_reg <= 1'b0;
                    if (eoi) begin
                        in_service_reg <= '0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    irq_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq        = irq_reg;
    assign irq_vec    = irq_vec_reg;
    assign pending    = pending_reg;
    assign in_service = in_service_reg;

endmodule

// File: tb/tb_int_prio_arb.sv
// -----------------------------------------------------------------------------
// tb_int_prio_arb
//
// Directed bench for int_prio_arb. One instance runs fixed priority, a second
// runs round-robin with level sources. Expected vectors are queued when the
// stimulus is driven and popped when the DUT raises irq.
// -----------------------------------------------------------------------------
module tb_int_prio_arb;

    localparam int N = 8;
    localparam int VW = 3;

    logic          cpu_clk = 1'b0;
    logic          cpu_reset = 1'b1;

    // Fixed-priority instance
    logic [N-1:0]  src_in = '0, src_edge = '1, src_en = '1, pend_clr = '0;
    logic          irq_ack = 1'b0, eoi = 1'b0;
    logic          irq;
    logic [VW-1:0] irq_vec;
    logic [N-1:0]  pending, in_service;

    // Round-robin instance
    logic [N-1:0]  rr_src_in = '0, rr_src_edge = '0, rr_src_en = '1, rr_pend_clr = '0;
    logic          rr_irq_ack = 1'b0, rr_eoi = 1'b0;
    logic          rr_irq;
    logic [VW-1:0] rr_irq_vec;
    logic [N-1:0]  rr_pending, rr_in_service;

    int errors = 0;
    int checks = 0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] rr_exp_q[$];

    always #5 cpu_clk = ~cpu_clk;

    int_prio_arb #(.N_SRC(N), .VEC_W(VW), .RR(0)) u_fp (
        .cpu_clk    (cpu_clk),
        .cpu_reset  (cpu_reset),
        .src_in     (src_in),
        .src_edge   (src_edge),
        .src_en     (src_en),
        .pend_clr   (pend_clr),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .pending    (pending),
        .in_service (in_service)
    );

    int_prio_arb #(.N_SRC(N), .VEC_W(VW), .RR(1)) u_rr (
        .cpu_clk    (cpu_clk),
        .cpu_reset  (cpu_reset),
        .src_in     (rr_src_in),
        .src_edge   (rr_src_edge),
        .src_en     (rr_src_en),
        .pend_clr   (rr_pend_clr),
        .irq        (rr_irq),
        .irq_vec    (rr_irq_vec),
        .irq_ack    (rr_irq_ack),
        .eoi        (rr_eoi),
        .pending    (rr_pending),
        .in_service (rr_in_service)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pop the next expected vector for the fixed-priority instance.
    task automatic pop_fp(input string tag);
        logic [VW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, irq_vec);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(irq_vec), 32'(e));
        end
    endtask

    initial begin
        int n;

        // ---------------- reset state ----------------
        tick();
        tick();
        cpu_reset = 1'b0;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);

        // ---------------- sources 2 and 5 rise together ----------------
        src_in = 8'h24;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        tick();
        check("pend_after_rise", 32'(pending), 32'h24);
        check("irq_t1", 32'(irq), 32'd0);
        tick();
        check("irq_t2", 32'(irq), 32'd1);
        pop_fp("vec_first");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_irq_low", 32'(irq), 32'd0);
        check("ack_in_service", 32'(in_service), 32'h04);
        check("ack_pend_cleared", 32'(pending), 32'h20);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("eoi_in_service", 32'(in_service), 32'd0);
        check("eoi_irq_low", 32'(irq), 32'd0);
        tick();
        check("irq_eoi_plus2", 32'(irq), 32'd1);
        pop_fp("vec_second");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        src_in = '0;
        tick();

        // ---------------- ack in IDLE ignored ----------------
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("idle_ack_irq", 32'(irq), 32'd0);
        check("idle_ack_vec", 32'(irq_vec), 32'd5);
        check("idle_ack_in_svc", 32'(in_service), 32'd0);

        // ---------------- withdraw on disable ----------------
        src_in = 8'h08;
        exp_q.push_back(3'd3);
        tick();
        tick();
        check("wd_irq", 32'(irq), 32'd1);
        pop_fp("wd_vec");
        // eoi while in ASSERT must not change anything
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("assert_eoi_irq", 32'(irq), 32'd1);
        check("assert_eoi_vec", 32'(irq_vec), 32'd3);
        src_en = 8'hF7;
        tick();
        check("wd_irq_drop", 32'(irq), 32'd0);
        check("wd_pend_kept", 32'(pending[3]), 32'd1);
        tick();
        check("wd_stay_idle", 32'(irq), 32'd0);
        src_en = 8'hFF;
        exp_q.push_back(3'd3);
        tick();
        check("reen_irq", 32'(irq), 32'd1);
        pop_fp("reen_vec");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("reen_pend_clr", 32'(pending), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        src_in = '0;
        tick();

        // ---------------- pend_clr versus rise ----------------
        src_en   = 8'hEF;
        src_in   = 8'h10;
        pend_clr = 8'h10;
        tick();
        check("clr_set_wins", 32'(pending), 32'h10);
        tick();
        check("clr_alone", 32'(pending), 32'h00);
        pend_clr = '0;
        src_en   = 8'hFF;
        src_in   = '0;
        tick();
        check("clr_no_irq", 32'(irq), 32'd0);

        // ---------------- reset during SERVICE ----------------
        src_in = 8'h02;
        exp_q.push_back(3'd1);
        tick();
        tick();
        check("svc_irq", 32'(irq), 32'd1);
        pop_fp("svc_vec");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("svc_in_service", 32'(in_service), 32'h02);
        src_in    = 8'h03;
        cpu_reset = 1'b1;
        #1;
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_in_service", 32'(in_service), 32'd0);
        check("arst_pending", 32'(pending), 32'd0);
        tick();
        tick();
        cpu_reset = 1'b0;
        exp_q.push_back(3'd0);
        tick();
        check("rel_pending", 32'(pending), 32'h03);
        check("rel_irq_t1", 32'(irq), 32'd0);
        tick();
        check("rel_irq_t2", 32'(irq), 32'd1);
        pop_fp("rel_vec");

        // ---------------- round-robin, level sources 0 and 1 ----------------
        rr_src_in = 8'h03;
        rr_exp_q.push_back(3'd0);
        rr_exp_q.push_back(3'd1);
        rr_exp_q.push_back(3'd0);
        rr_exp_q.push_back(3'd1);
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!rr_irq && n < 10) begin
                tick();
                n++;
            end
            if (!rr_irq) begin
                checks++;
                errors++;
                $error("FAIL rr_timeout: observed=irq low expected=irq high within 10 cycles");
            end else if (rr_exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rr_vec: observed=%0h expected=<empty scoreboard>", rr_irq_vec);
            end else begin
                logic [VW-1:0] e;
                e = rr_exp_q.pop_front();
                check($sformatf("rr_vec_%0d", r), 32'(rr_irq_vec), 32'(e));
            end
            rr_irq_ack = 1'b1;
            tick();
            rr_irq_ack = 1'b0;
            eoi_rr_pulse();
        end
        rr_src_in = '0;

        check("sb_fp_empty", 32'(exp_q.size()), 32'd0);
        check("sb_rr_empty", 32'(rr_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic eoi_rr_pulse();
        rr_eoi = 1'b1;
        tick();
        rr_eoi = 1'b0;
    endtask

endmodule

// File: doc/int_prio_arb.md
# int_prio_arb

Priority arbiter and handshake sequencer for the interrupt sources feeding the CPU. It sits between the per-source enable/edge configuration registers and the CPU interrupt pin. It latches source events into pending bits and selects one winner, either by fixed priority or round-robin. It then runs an assert → acknowledge → end-of-interrupt handshake, so the CPU services exactly one source at a time and always has a stable vector to read.

## Interface
- N_SRC, 8, number of interrupt sources (2..32)
- VEC_W, 3, vector width; must equal ceil(log2(N_SRC))
- RR, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- cpu_clk  in  1  single clock; all logic on its rising edge
- cpu_reset  in  1  asynchronous, active-high reset
- src_in  in  N_SRC  raw source lines, already synchronized to cpu_clk
- src_edge  in  N_SRC  per-source mode: 1 = rising-edge triggered, 0 = level
- src_en  in  N_SRC  per-source enable
- pend_clr  in  N_SRC  one-cycle pulse per bit; clears edge-mode pending bits
- irq  out  1  interrupt request to CPU (registered)
- irq_vec  out  VEC_W  index of the requesting/in-service source (registered)
- irq_ack  in  1  CPU accepts the current vector (one-cycle pulse)
- eoi  in  1  CPU signals end of interrupt (one-cycle pulse)
- pending  out  N_SRC  pending bits (registered)
- in_service  out  N_SRC  one-hot in-service source; zero when none

## Operation
- Edge detect: src_d <= src_in; rise = src_in & ~src_d. src_d resets to 0, so a line already high at reset release counts as one edge.
- Pending, edge mode: set on rise; cleared by pend_clr or by irq_ack while that source is the vector. Set has priority over any same-cycle clear.
- Pending, level mode: pend <= src_in every cycle. pend_clr and irq_ack have no effect on level-mode bits.
- eligible = pending & src_en (combinational).
- Winner selection:
  - RR=0: lowest-index eligible bit.
  - RR=1: first eligible bit at or after ptr+1, wrapping modulo N_SRC. ptr updates to the winner on irq_ack.
- FSM states:
  - IDLE: irq=0. If eligible≠0, register the winner into irq_vec and go to ASSERT.
  - ASSERT: irq=1 and irq_vec is held. A higher-priority arrival does not change the vector (no preemption).
    - On irq_ack: clear the vector's edge pending bit, set in_service[irq_vec], go to SERVICE.
    - Else, if eligible[irq_vec] has dropped (disabled, cleared, or level removed): withdraw, irq=0, go to IDLE.
    - If ack and drop occur in the same cycle, ack wins.
  - SERVICE: irq=0 and irq_vec is held. On eoi: clear in_service, go to IDLE.
- irq_ack outside ASSERT and eoi outside SERVICE are ignored.
- Level sources are not auto-cleared. If the device line is still high at eoi, the same source re-requests.
- Reset (any time, mid-handshake included): state=IDLE; irq=0, irq_vec=0, pending=0, in_service=0, src_d=0, ptr=N_SRC-1 (so source 0 wins the first RR round).

## Timing
- src_in rise at cycle t: pending bit visible at t+1, irq=1 at t+2. The minimum request latency is 2 cycles.
- irq_ack sampled at a: irq=0, in_service set and edge pending cleared, all visible at a+1.
- eoi sampled at e: in_service=0 and state IDLE at e+1. The earliest next irq is e+2.
- A withdraw detected at w gives irq=0 at w+1.
- Minimum back-to-back service: 2 cycles of IDLE→ASSERT per interrupt, plus the CPU handshake time.
- A new edge on a source in SERVICE re-sets its pending bit. It is served after eoi.

## Test plan
- RR=0; edge sources 2 and 5 rise in the same cycle t → irq=1, irq_vec=2 at t+2. After ack and eoi, irq_vec=5 at eoi+2.
- RR=1; sources 0 and 1 held level-high, with ack/eoi run repeatedly → irq_vec sequence 0,1,0,1.
- Edge source 3 pending, then src_en[3]=0 during ASSERT → irq drops one cycle later, state returns to IDLE, pending[3] stays 1.
- pend_clr[4] in the same cycle as rise on source 4 → pending[4]=1 (set wins). pend_clr[4] alone next cycle → pending[4]=0.
- irq_ack pulsed in IDLE and eoi pulsed in ASSERT → no state change; irq/irq_vec unchanged.
- cpu_reset asserted during SERVICE → irq=0, in_service=0, pending=0 immediately. A source high at reset release gives irq at release+2.
